bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-port round-robin arbiter that shares the single CPU bus master between the instruction-fetch path (port 0) and the load/store path (port 1). It sits upstream of the bus controller top and drives that controller's start_transaction, mode, address and write data from the winning requester. It then waits for the controller's completion pulse and returns the result to the winner with a one-cycle done pulse. An optional lock lets port 1 hold the bus across a read-modify-write pair.

## Interface
Parameters:
- DATA_WIDTH, 32, width of data on both ports and to the bus master
- ADDR_WIDTH, 32, width of addresses on both ports and to the bus master

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- pN_req  in  1  request from port N (N = 0, 1); level, held until pN_done
- pN_mode  in  1  0 read, 1 write; stable while pN_req is high
- pN_addr  in  ADDR_WIDTH  address; stable while pN_req is high
- pN_wdata  in  DATA_WIDTH  write data; stable while pN_req is high
- pN_done  out  1  one-cycle completion pulse to port N
- pN_rdata  out  DATA_WIDTH  read data; valid in the pN_done cycle of a read
- p1_lock  in  1  sampled at port 1 completion; if high, port 1 keeps priority for its next request
- bm_start  out  1  one-cycle pulse to the bus master's start_transaction
- bm_mode  out  1  to the bus master's mode
- bm_addr  out  ADDR_WIDTH  to the bus master's address input
- bm_wdata  out  DATA_WIDTH  to the bus master's write data input
- bm_rdata_valid  in  1  read completion pulse from the bus master
- bm_write_done  in  1  write completion pulse from the bus master
- bm_rdata  in  DATA_WIDTH  read data, valid with bm_rdata_valid
- busy  out  1  high in every state except IDLE

## Operation
- FSM states:
  - IDLE: if any pN_req is high, pick a winner, latch its mode/addr/wdata into internal registers, record the grant, then go to ISSUE.
  - ISSUE: bm_start = 1 for exactly one cycle, then go to WAIT.
  - WAIT: hold the latched values on bm_*.
    - For a read, leave on bm_rdata_valid and capture bm_rdata.
    - For a write, leave on bm_write_done.
    - The completion pulse that does not match the latched mode is ignored.
    - Go to RESP.
  - RESP: pulse done on the granted port only; pN_rdata holds the captured data. Go to IDLE.
- Arbitration in IDLE:
  - With one request, that port wins.
  - With both requests, the port that did not win last time wins.
  - After reset, the last winner is initialised to port 1, so port 0 wins first.
  - If lock_hold is set and p1_req is high, port 1 wins regardless of the round-robin state.
- lock_hold:
  - Set in RESP when the granted port is 1 and p1_lock = 1.
  - Cleared in RESP for any other completion.
  - Also cleared in IDLE when p1_req is low, so port 0 is never starved by a stale lock.
- bm_addr, bm_mode and bm_wdata come only from the latched registers, never directly from port inputs. Changes on a port input after latching have no effect.
- A port deasserting pN_req mid-transaction is ignored: the transaction completes and pN_done still pulses.
- A port holding pN_req high through the IDLE cycle after its pN_done is treated as a new request.

## Timing
- Reset values:
  - state IDLE; busy, bm_start, p0_done, p1_done 0
  - bm_mode 0, bm_addr 0, bm_wdata 0
  - p0_rdata 0, p1_rdata 0
  - lock_hold 0, last winner = port 1
- Latency example: request high in cycle 0 (IDLE) → bm_start in cycle 1 → controller completion in cycle k ≥ 2 → pN_done in cycle k+1 → IDLE in cycle k+2.
- Minimum requester-visible latency is 3 cycles (req to done). Maximum back-to-back throughput is one transaction per 4 cycles.
- A completion pulse arriving in IDLE, ISSUE or RESP is ignored.
- Reset asserted mid-transaction returns everything to reset values immediately. No done pulse is issued for the aborted transaction.

## Structure
- bus_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP)
  - port index constants PORT_IF = 0 and PORT_LS = 1
  - mode constants MODE_READ = 0 and MODE_WRITE = 1, shared with the bus controller's mode encoding
- One sub-module, rr_pick2: purely combinational winner select with inputs req[1:0], last, force1 and output win.
- The top level instantiates rr_pick2 next to the FSM and latch registers, and feeds the bus controller top.

## Test plan
- Port 0 read of 0x0000_1000 alone, with bm_rdata = 0xDEAD_BEEF returned in cycle 3 → bm_start in cycle 1 only, p0_done in cycle 4, p0_rdata = 0xDEAD_BEEF, p1_done stays 0.
- Both ports request together, three times with req held high → grant order 0, 1, 0. The winner's address appears on bm_addr each time.
- Port 1 write to 0x10, wdata 0x55AA, with port 1 changing its inputs after bm_start → bm_addr stays 0x10 and bm_wdata stays 0x55AA until RESP. p1_done pulses once.
- Port 1 with p1_lock = 1, port 0 also requesting → port 1 wins twice in a row. On the next contention after port 1 completes with p1_lock = 0, port 0 wins.
- During a read, bm_write_done pulses before bm_rdata_valid → bm_write_done is ignored, and the port's done pulse follows bm_rdata_valid.
- rst_n pulled low during WAIT → all outputs reach reset values in the same cycle. After release, no done pulse appears, and port 0 wins the first contention.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and encodings for the two-port bus arbiter.
// The mode encoding matches the bus controller's mode input.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic PORT_IF    = 1'b0;
    localparam logic PORT_LS    = 1'b1;
    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin winner select.
// Port 1 can be forced to win while it holds a lock.
module rr_pick2
    import bus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       force1,
    output logic       win
);

    always_comb begin
        win = PORT_IF;
        if (force1 && req[1]) begin
            win = PORT_LS;
        end else if (&req) begin
            win = ~last;
        end else if (req[1]) begin
            win = PORT_LS;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one bus master between instruction fetch
// (port 0) and load/store (port 1), with an optional port 1 lock.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req,
    input  logic                  p0_mode,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_done,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_mode,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_done,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    input  logic                  p1_lock,
    output logic                  bm_start,
    output logic                  bm_mode,
    output logic [ADDR_WIDTH-1:0] bm_addr,
    output logic [DATA_WIDTH-1:0] bm_wdata,
    input  logic                  bm_rdata_valid,
    input  logic                  bm_write_done,
    input  logic [DATA_WIDTH-1:0] bm_rdata,
    output logic                  busy
);

    state_t                state_q, state_d;
    logic                  last_q;
    logic                  lock_q;
    logic                  grant_q;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  win;
    logic                  any_req;
    logic                  complete;

    assign any_req = p0_req | p1_req;

    rr_pick2 u_pick (
        .req    ({p1_req, p0_req}),
        .last   (last_q),
        .force1 (lock_q),
        .win    (win)
    );

    // Only the completion matching the latched mode ends the transaction.
    assign complete = (mode_q == MODE_READ) ? bm_rdata_valid : bm_write_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bm_start = 1'b0;
        busy     = 1'b1;
        p0_done  = 1'b0;
        p1_done  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (any_req) state_d = ISSUE;
            end
            ISSUE: begin
                bm_start = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (complete) state_d = RESP;
            end
            RESP: begin
                p0_done = (grant_q == PORT_IF);
                p1_done = (grant_q == PORT_LS);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q  <= PORT_LS;
            lock_q  <= 1'b0;
            grant_q <= PORT_IF;
            mode_q  <= MODE_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A lock is dropped as soon as port 1 stops asking.
                    if (!p1_req) lock_q <= 1'b0;
                    if (any_req) begin
                        grant_q <= win;
                        last_q  <= win;
                        mode_q  <= win ? p1_mode  : p0_mode;
                        addr_q  <= win ? p1_addr  : p0_addr;
                        wdata_q <= win ? p1_wdata : p0_wdata;
                    end
                end
                WAIT: begin
                    if (mode_q == MODE_READ && bm_rdata_valid) rdata_q <= bm_rdata;
                end
                RESP: begin
                    lock_q <= (grant_q == PORT_LS) && p1_lock;
                end
                default: ;
            endcase
        end
    end

    assign bm_mode  = mode_q;
    assign bm_addr  = addr_q;
    assign bm_wdata = wdata_q;
    assign p0_rdata = rdata_q;
    assign p1_rdata = rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Table-driven bench for bus_arbiter with a scoreboard of expected grants
// and read data, plus hand sequences for idle completions and reset abort.
module tb_bus_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          p0_req = 1'b0, p0_mode = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p0_done;
    logic [DW-1:0] p0_rdata;
    logic          p1_req = 1'b0, p1_mode = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          p1_done;
    logic [DW-1:0] p1_rdata;
    logic          p1_lock = 1'b0;
    logic          bm_start, bm_mode;
    logic [AW-1:0] bm_addr;
    logic [DW-1:0] bm_wdata;
    logic          bm_rdata_valid = 1'b0, bm_write_done = 1'b0;
    logic [DW-1:0] bm_rdata = '0;
    logic          busy;

    bus_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_mode(p0_mode), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_mode(p1_mode), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_lock(p1_lock),
        .bm_start(bm_start), .bm_mode(bm_mode), .bm_addr(bm_addr), .bm_wdata(bm_wdata),
        .bm_rdata_valid(bm_rdata_valid), .bm_write_done(bm_write_done), .bm_rdata(bm_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic          p0r, p0m;
        logic [AW-1:0] p0a;
        logic [DW-1:0] p0w;
        logic          p1r, p1m;
        logic [AW-1:0] p1a;
        logic [DW-1:0] p1w;
        logic          lock;
        int            lat;
        logic          spur;
        logic          scram;
        logic [DW-1:0] resp;
        logic          port;
    } vec_t;

    typedef struct {
        logic          port;
        logic          mode;
        logic [DW-1:0] rdata;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic p0r, input logic p0m, input logic [AW-1:0] p0a,
                                input logic [DW-1:0] p0w, input logic p1r, input logic p1m,
                                input logic [AW-1:0] p1a, input logic [DW-1:0] p1w,
                                input logic lock, input int lat, input logic spur,
                                input logic scram, input logic [DW-1:0] resp, input logic port);
        vec_t v;
        v.p0r = p0r; v.p0m = p0m; v.p0a = p0a; v.p0w = p0w;
        v.p1r = p1r; v.p1m = p1m; v.p1a = p1a; v.p1w = p1w;
        v.lock = lock; v.lat = lat; v.spur = spur; v.scram = scram;
        v.resp = resp; v.port = port;
        return v;
    endfunction

    task automatic drive_vec(input vec_t v);
        exp_t e;
        p0_req = v.p0r; p0_mode = v.p0m; p0_addr = v.p0a; p0_wdata = v.p0w;
        p1_req = v.p1r; p1_mode = v.p1m; p1_addr = v.p1a; p1_wdata = v.p1w;
        e.port  = v.port;
        e.mode  = v.port ? v.p1m : v.p0m;
        e.rdata = v.resp;
        sb.push_back(e);
    endtask

    task automatic run_vec(input int idx, input bit from_idle);
        vec_t          v;
        exp_t          e;
        int            n;
        bit            seen_done, hold_ok;
        logic [AW-1:0] ea;
        logic          em;
        logic [DW-1:0] ew;
        v  = vecs[idx];
        ea = v.port ? v.p1a : v.p0a;
        em = v.port ? v.p1m : v.p0m;
        ew = v.port ? v.p1w : v.p0w;
        n = 0;
        seen_done = 0;
        while (!bm_start && n < 8) begin
            @(negedge clk);
            n++;
            if (p0_done || p1_done) seen_done = 1;
        end
        check($sformatf("v%0d_no_extra_done", idx), seen_done, 0);
        check($sformatf("v%0d_start_seen", idx), bm_start, 1);
        if (!bm_start) return;
        check($sformatf("v%0d_start_latency", idx), n, from_idle ? 1 : 2);
        check($sformatf("v%0d_bm_addr", idx), bm_addr, ea);
        check($sformatf("v%0d_bm_mode", idx), bm_mode, em);
        check($sformatf("v%0d_bm_wdata", idx), bm_wdata, ew);
        p1_lock = v.lock;
        if (v.scram) begin
            if (v.port) begin
                p1_addr = ~p1_addr; p1_wdata = ~p1_wdata; p1_mode = ~p1_mode;
            end else begin
                p0_addr = ~p0_addr; p0_wdata = ~p0_wdata; p0_mode = ~p0_mode;
            end
        end
        hold_ok = 1;
        for (int c = 1; c <= v.lat; c++) begin
            @(negedge clk);
            bm_rdata_valid = 1'b0;
            bm_write_done  = 1'b0;
            bm_rdata       = 32'h5A5A_0000 + DW'(c);
            if (bm_start || p0_done || p1_done || !busy ||
                bm_addr !== ea || bm_wdata !== ew || bm_mode !== em) hold_ok = 0;
            if (v.spur && c == v.lat - 1) begin
                if (em) bm_rdata_valid = 1'b1;
                else    bm_write_done  = 1'b1;
            end
            if (c == v.lat) begin
                if (em) bm_write_done = 1'b1;
                else begin
                    bm_rdata_valid = 1'b1;
                    bm_rdata       = v.resp;
                end
            end
        end
        @(negedge clk);
        bm_rdata_valid = 1'b0;
        bm_write_done  = 1'b0;
        bm_rdata       = 32'hA5A5_A5A5;
        if (bm_addr !== ea || bm_wdata !== ew) hold_ok = 0;
        check($sformatf("v%0d_hold_in_wait", idx), hold_ok, 1);
        if (sb.size() == 0) begin
            check($sformatf("v%0d_scoreboard_empty", idx), 1, 0);
            return;
        end
        e = sb.pop_front();
        check($sformatf("v%0d_done_onehot", idx), {p1_done, p0_done}, e.port ? 2'b10 : 2'b01);
        if (e.mode == 1'b0)
            check($sformatf("v%0d_rdata", idx), e.port ? p1_rdata : p0_rdata, e.rdata);
    endtask

    initial begin
        bit            bad;
        int            n;
        //          p0r p0m p0a            p0w            p1r p1m p1a            p1w            lk lat sp sc resp           port
        vecs[0] = mk(1, 0, 32'h0000_1000, 32'h0,         0, 0, 32'h0,         32'h0,         0, 2, 0, 0, 32'hDEAD_BEEF, 0);
        vecs[1] = mk(0, 0, 32'h0,         32'h0,         1, 1, 32'h0000_0010, 32'h0000_55AA, 0, 3, 0, 1, 32'h0,         1);
        vecs[2] = mk(1, 0, 32'h0000_0200, 32'h0,         1, 0, 32'h0000_0300, 32'h0,         0, 1, 0, 0, 32'h1111_2222, 0);
        vecs[3] = mk(1, 1, 32'h0000_0204, 32'hAAAA_0001, 1, 1, 32'h0000_0304, 32'hBBBB_0002, 0, 2, 0, 0, 32'h0,         1);
        vecs[4] = mk(1, 0, 32'h0000_0208, 32'h0,         1, 1, 32'h0000_0308, 32'hCCCC_0003, 0, 3, 1, 0, 32'hCAFE_F00D, 0);
        vecs[5] = mk(1, 0, 32'h0000_0500, 32'h0,         1, 0, 32'h0000_0400, 32'h0,         1, 2, 0, 0, 32'h0BAD_CAFE, 1);
        vecs[6] = mk(1, 0, 32'h0000_0500, 32'h0,         1, 1, 32'h0000_0404, 32'h0000_0077, 0, 2, 1, 0, 32'h0,         1);
        vecs[7] = mk(1, 0, 32'h0000_0504, 32'h0,         1, 0, 32'h0000_0408, 32'h0,         0, 1, 0, 0, 32'h1234_5678, 0);
        vecs[8] = mk(1, 0, 32'h0000_0A00, 32'h0,         1, 0, 32'h0000_0B00, 32'h0,         0, 2, 0, 0, 32'h0F0F_0F0F, 0);

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_bm_start", bm_start, 0);
        check("reset_dones", {p1_done, p0_done}, 2'b00);
        check("reset_bm_fields", {bm_mode, bm_addr, bm_wdata}, '0);
        check("reset_rdata", {p0_rdata, p1_rdata}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Completion pulses while idle must not start anything.
        bm_rdata_valid = 1'b1;
        bm_write_done  = 1'b1;
        @(negedge clk);
        bm_rdata_valid = 1'b0;
        bm_write_done  = 1'b0;
        check("idle_completion_busy", busy, 0);
        @(negedge clk);
        check("idle_completion_done", {p1_done, p0_done, busy}, 3'b000);

        drive_vec(vecs[0]);
        for (int i = 0; i < 8; i++) begin
            run_vec(i, i == 0);
            if (i < 7) drive_vec(vecs[i + 1]);
            else begin
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
        end

        // Abort a read in WAIT with reset; last winner must return to port 1.
        @(negedge clk);
        p0_req = 1'b1; p0_mode = 1'b0; p0_addr = 32'h0000_0900;
        n = 0;
        while (!bm_start && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("abort_start_seen", bm_start, 1);
        @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_bm_fields", {bm_start, bm_mode, bm_addr, bm_wdata}, '0);
        check("abort_rdata", {p0_rdata, p1_rdata}, '0);
        check("abort_dones", {p1_done, p0_done}, 2'b00);
        @(negedge clk);
        p0_req = 1'b0;
        rst_n  = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (p0_done || p1_done || busy) bad = 1;
        end
        check("abort_no_done_after", bad, 0);
        drive_vec(vecs[8]);
        run_vec(8, 1'b1);
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (2) @(negedge clk);
        check("final_scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
